// File: rtl/branch_predict_fetch_pkg.sv
// Shared types and counter helpers for the branch-predicting fetch stage.
package rvscc_bp_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } cnt_t;

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == STRONG_T) ? STRONG_T : cnt_t'(c + 2'b01);
  endfunction

  function automatic cnt_t sat_dec(input cnt_t c);
    return (c == STRONG_NT) ? STRONG_NT : cnt_t'(c - 2'b01);
  endfunction

endpackage

// File: rtl/branch_predict_fetch_if.sv
// Fetch-side and execute-resolution signals of the branch-predicting front end.
interface branch_predict_fetch_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus_4;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_target;
  logic            ex_valid;
  logic            ex_is_jump;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispredict;

  modport master (
    output stall, ex_valid, ex_is_jump, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  if_pc, if_pc_plus_4, if_pred_taken, if_pred_target,
           mispredict, redirect_pc, perf_branches, perf_mispredict
  );

  modport slave (
    input  stall, ex_valid, ex_is_jump, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output if_pc, if_pc_plus_4, if_pred_taken, if_pred_target,
           mispredict, redirect_pc, perf_branches, perf_mispredict
  );
endinterface

// File: rtl/branch_predict_fetch_btb_table.sv
// Direct-mapped BTB storage: fetch read port, resolution probe port, one write port.
module branch_predict_fetch_btb_table
  import rvscc_bp_pkg::*;
#(
  parameter int   XLEN        = 32,
  parameter int   BTB_ENTRIES = 16,
  parameter cnt_t CNT_INIT    = WEAK_NT,
  localparam int  IDX         = $clog2(BTB_ENTRIES),
  localparam int  TAG_W       = XLEN - IDX - 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX-1:0]    rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [XLEN-3:0]   rd_target,
  output logic              rd_is_jump,
  output cnt_t              rd_cnt,
  input  logic [IDX-1:0]    up_idx,
  output logic              up_valid,
  output logic [TAG_W-1:0]  up_tag,
  output cnt_t              up_cnt,
  input  logic              we_entry,
  input  logic              we_cnt,
  input  logic [IDX-1:0]    wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [XLEN-3:0]   wr_target,
  input  logic              wr_is_jump,
  input  cnt_t              wr_cnt
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-3:0]  target;
    logic             is_jump;
  } btb_entry_t;

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  cnt_t                   cnt_q   [BTB_ENTRIES];
  cnt_t                   cnt_d   [BTB_ENTRIES];
  btb_entry_t             entry_q [BTB_ENTRIES];
  btb_entry_t             entry_d [BTB_ENTRIES];

  // Reads are combinational on the registered contents, so a same-index write shows up next cycle
  assign rd_valid   = valid_q[rd_idx];
  assign rd_tag     = entry_q[rd_idx].tag;
  assign rd_target  = entry_q[rd_idx].target;
  assign rd_is_jump = entry_q[rd_idx].is_jump;
  assign rd_cnt     = cnt_q[rd_idx];
  assign up_valid   = valid_q[up_idx];
  assign up_tag     = entry_q[up_idx].tag;
  assign up_cnt     = cnt_q[up_idx];

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    entry_d = entry_q;
    if (we_entry) begin
      valid_d[wr_idx] = 1'b1;
      entry_d[wr_idx] = '{tag: wr_tag, target: wr_target, is_jump: wr_is_jump};
    end
    if (we_cnt) cnt_d[wr_idx] = wr_cnt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) cnt_q[i] <= CNT_INIT;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry payload is qualified by valid, so it needs no reset
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule

// File: rtl/branch_predict_fetch.sv
// Fetch stage: PC register, BTB-driven next-PC prediction, execute-time mispredict and redirect.
module branch_predict_fetch
  import rvscc_bp_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [1:0]      CNT_INIT    = 2'b01
) (
  input logic                  clk,
  input logic                  reset,
  branch_predict_fetch_if.slave bus
);

  localparam int              IDX   = $clog2(BTB_ENTRIES);
  localparam int              TAG_W = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] FOUR  = XLEN'(4);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      perf_br_q, perf_br_d, perf_mp_q, perf_mp_d;
  logic [XLEN-1:0]  pc_plus_4, pred_target, redirect_pc;
  logic             lk_hit, up_hit, pred_taken, mispredict;
  logic             rd_valid, rd_is_jump, up_valid, we_entry, we_cnt;
  logic [TAG_W-1:0] rd_tag, up_tag;
  logic [XLEN-3:0]  rd_target;
  cnt_t             rd_cnt, up_cnt, wr_cnt;

  branch_predict_fetch_btb_table #(
    .XLEN(XLEN), .BTB_ENTRIES(BTB_ENTRIES), .CNT_INIT(cnt_t'(CNT_INIT))
  ) u_btb (
    .clk(clk), .reset(reset),
    .rd_idx(pc_q[IDX+1:2]), .rd_valid(rd_valid), .rd_tag(rd_tag),
    .rd_target(rd_target), .rd_is_jump(rd_is_jump), .rd_cnt(rd_cnt),
    .up_idx(bus.ex_pc[IDX+1:2]), .up_valid(up_valid), .up_tag(up_tag), .up_cnt(up_cnt),
    .we_entry(we_entry), .we_cnt(we_cnt), .wr_idx(bus.ex_pc[IDX+1:2]),
    .wr_tag(bus.ex_pc[XLEN-1:IDX+2]), .wr_target(bus.ex_target[XLEN-1:2]),
    .wr_is_jump(bus.ex_is_jump), .wr_cnt(wr_cnt)
  );

  always_comb begin
    pc_plus_4   = pc_q + FOUR;
    lk_hit      = rd_valid && (rd_tag == pc_q[XLEN-1:IDX+2]);
    pred_taken  = lk_hit && (rd_is_jump || rd_cnt == WEAK_T || rd_cnt == STRONG_T);
    pred_target = lk_hit ? {rd_target, 2'b00} : pc_plus_4;
    mispredict  = reset && bus.ex_valid &&
                  ((bus.ex_taken != bus.ex_pred_taken) ||
                   (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
    redirect_pc = bus.ex_taken ? bus.ex_target : (bus.ex_pc + FOUR);

    // Redirect wins over stall: the hazard unit flushes the stalled decode slot
    if (mispredict)      pc_d = redirect_pc;
    else if (bus.stall)  pc_d = pc_q;
    else if (pred_taken) pc_d = pred_target;
    else                 pc_d = pc_plus_4;

    up_hit   = up_valid && (up_tag == bus.ex_pc[XLEN-1:IDX+2]);
    we_entry = 1'b0;
    we_cnt   = 1'b0;
    wr_cnt   = up_cnt;
    if (reset && bus.ex_valid) begin
      if (bus.ex_taken) begin
        we_entry = 1'b1;
        we_cnt   = 1'b1;
        wr_cnt   = bus.ex_is_jump ? STRONG_T : (up_hit ? sat_inc(up_cnt) : WEAK_T);
      end else if (up_hit) begin
        we_cnt = 1'b1;
        wr_cnt = sat_dec(up_cnt);
      end
    end

    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (bus.ex_valid && perf_br_q != 32'hFFFF_FFFF) perf_br_d = perf_br_q + 32'd1;
    if (mispredict && perf_mp_q != 32'hFFFF_FFFF)   perf_mp_d = perf_mp_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      pc_q      <= pc_d;
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign bus.if_pc           = pc_q;
  assign bus.if_pc_plus_4    = pc_plus_4;
  assign bus.if_pred_taken   = pred_taken;
  assign bus.if_pred_target  = pred_target;
  assign bus.mispredict      = mispredict;
  assign bus.redirect_pc     = redirect_pc;
  assign bus.perf_branches   = perf_br_q;
  assign bus.perf_mispredict = perf_mp_q;

endmodule

// File: tb/tb_branch_predict_fetch.sv
// Directed bench for branch_predict_fetch with a queue-based scoreboard of expected values.
module tb_branch_predict_fetch;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predict_fetch_if #(.XLEN(32)) bus ();

  branch_predict_fetch #(
    .XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0), .CNT_INIT(2'b01)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int n_br  = 0;
  int n_mp  = 0;
  logic [31:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    exp_q.push_back(e);
    pop_chk(tag, obs);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    bus.ex_valid   = 1'b0;
    bus.ex_is_jump = 1'b0;
    bus.ex_taken   = 1'b0;
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic jmp,
                         input logic [31:0] tgt, input logic ptk,
                         input logic [31:0] ptgt, input logic mp);
    bus.ex_valid       = 1'b1;
    bus.ex_pc          = pc;
    bus.ex_taken       = tk;
    bus.ex_is_jump     = jmp;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt;
    exp_q.push_back({31'd0, mp});
    exp_q.push_back(tk ? tgt : pc + 32'd4);
    if (reset) begin
      n_br++;
      if (mp) n_mp++;
    end
    #1;
    pop_chk("mispredict", {31'd0, bus.mispredict});
    pop_chk("redirect_pc", bus.redirect_pc);
  endtask

  task automatic redirect(input logic [31:0] a);
    resolve(a - 32'd4, 1'b0, 1'b0, 32'h0, 1'b1, a, 1'b1);
    nxt();
    chk("redir_if_pc", bus.if_pc, a);
  endtask

  task automatic look(input string tag, input logic tk, input logic [31:0] tgt);
    chk({tag, "_taken"}, {31'd0, bus.if_pred_taken}, {31'd0, tk});
    chk({tag, "_target"}, bus.if_pred_target, tgt);
  endtask

  initial begin
    reset              = 1'b0;
    bus.stall          = 1'b0;
    bus.ex_valid       = 1'b0;
    bus.ex_is_jump     = 1'b0;
    bus.ex_pc          = '0;
    bus.ex_taken       = 1'b0;
    bus.ex_target      = '0;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = '0;

    // Reset and sequential fetch
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_pc", bus.if_pc, 32'h0);
    reset = 1'b1;
    #1;
    chk("rst_pred_taken", {31'd0, bus.if_pred_taken}, 32'd0);
    chk("rst_perf_br", bus.perf_branches, 32'd0);
    chk("rst_perf_mp", bus.perf_mispredict, 32'd0);
    chk("rst_plus4", bus.if_pc_plus_4, 32'h4);
    nxt();
    chk("seq_pc4", bus.if_pc, 32'h4);
    bus.stall = 1'b1;
    nxt();
    chk("stall_hold", bus.if_pc, 32'h4);
    bus.stall = 1'b0;
    nxt();
    chk("seq_pc8", bus.if_pc, 32'h8);

    // Cold taken branch allocates, refetch predicts it
    resolve(32'h10, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1);
    nxt();
    chk("cold_redirect", bus.if_pc, 32'h40);
    redirect(32'h10);
    look("cold_refetch", 1'b1, 32'h40);

    // Counter training down to STRONG_NT, saturation, and back up
    resolve(32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    nxt();
    redirect(32'h10);
    look("dec1", 1'b0, 32'h40);
    resolve(32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    nxt();
    redirect(32'h10);
    look("dec2", 1'b0, 32'h40);
    resolve(32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    nxt();
    resolve(32'h10, 1'b1, 1'b0, 32'h40, 1'b1, 32'h40, 1'b0);
    nxt();
    redirect(32'h10);
    look("sat_then_inc", 1'b0, 32'h40);
    resolve(32'h10, 1'b1, 1'b0, 32'h40, 1'b1, 32'h40, 1'b0);
    nxt();
    redirect(32'h10);
    look("inc_to_weak_t", 1'b1, 32'h40);

    // Aliasing: 'h50 shares the index of 'h10 and evicts it
    resolve(32'h50, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 1'b1);
    nxt();
    chk("alias_redirect", bus.if_pc, 32'h80);
    redirect(32'h10);
    look("alias_old", 1'b0, 32'h14);
    redirect(32'h50);
    look("alias_new", 1'b1, 32'h80);

    // Stall with mispredict, update to the index being looked up
    bus.stall = 1'b1;
    resolve(32'h50, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    look("same_idx_old", 1'b1, 32'h80);
    nxt();
    chk("redirect_over_stall", bus.if_pc, 32'h54);
    nxt();
    chk("stall_hold2", bus.if_pc, 32'h54);
    bus.stall = 1'b0;
    redirect(32'h50);
    look("same_idx_new", 1'b0, 32'h80);

    // JAL allocates STRONG_T
    resolve(32'h20, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    nxt();
    chk("jal_redirect", bus.if_pc, 32'h100);
    redirect(32'h20);
    look("jal_lookup", 1'b1, 32'h100);
    resolve(32'h20, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    nxt();
    resolve(32'h20, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1);
    nxt();
    resolve(32'h20, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    nxt();
    redirect(32'h20);
    look("jal_cnt_strong", 1'b1, 32'h100);

    // PC wrap
    redirect(32'hFFFF_FFFC);
    look("wrap", 1'b0, 32'h0);
    chk("wrap_plus4", bus.if_pc_plus_4, 32'h0);
    nxt();
    chk("wrap_pc", bus.if_pc, 32'h0);
    chk("perf_br", bus.perf_branches, n_br);
    chk("perf_mp", bus.perf_mispredict, n_mp);

    // Mid-operation reset suppresses mispredict and the table update
    reset = 1'b0;
    resolve(32'h30, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 1'b0);
    nxt();
    nxt();
    n_br = 0;
    n_mp = 0;
    chk("rst2_pc", bus.if_pc, 32'h0);
    chk("rst2_perf_br", bus.perf_branches, 32'd0);
    chk("rst2_perf_mp", bus.perf_mispredict, 32'd0);
    reset = 1'b1;
    redirect(32'h30);
    look("rst2_no_alloc", 1'b0, 32'h34);
    redirect(32'h10);
    look("rst2_cleared", 1'b0, 32'h14);
    chk("final_perf_br", bus.perf_branches, n_br);
    chk("final_perf_mp", bus.perf_mispredict, n_mp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
